// File: rtl/event_counter_pkg.sv
// Shared types for the event counter: counting mode at the boundaries.
package event_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/debouncer.sv
// Synchronises a raw event input, debounces it and emits a one-cycle step on
// each accepted rising level.
module debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_impulse,
  output logic o_step
);

  localparam int unsigned RunW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RunW-1:0] RunLast = RunW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_level_d;
  logic                   r_step;
  logic [RunW-1:0]        r_run;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];
  assign o_step   = r_step;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_step    <= 1'b0;
      r_run     <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_impulse};
      r_level_d <= r_level;
      r_step    <= r_level & ~r_level_d;
      // The run counts consecutive disagreeing samples; the last one flips the level.
      if (w_sample == r_level) begin
        r_run <= '0;
      end else if (r_run == RunLast) begin
        r_level <= ~r_level;
        r_run   <= '0;
      end else begin
        r_run <= r_run + RunW'(1);
      end
    end
  end

endmodule

// File: rtl/event_counter.sv
// Up/down event counter driven by a debounced asynchronous input, with wrap or
// saturate behaviour at the boundaries and a sticky boundary flag.
module event_counter
  import event_counter_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter logic [31:0] RESET_VAL       = 32'hFF00,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_impulse,
  input  logic             i_enable,
  input  logic             i_up_down,
  input  cnt_mode_e        i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clr_flags,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_boundary_sticky
);

  localparam logic [WIDTH-1:0] ResetVal = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MaxVal   = '1;
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic             w_step;
  logic [WIDTH-1:0] w_count_d;
  logic             w_wrap_d;
  logic             w_hit;
  logic             w_sticky_d;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sticky;

  debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .nrst     (nrst),
    .i_impulse(i_impulse),
    .o_step   (w_step)
  );

  always_comb begin
    w_count_d = r_count;
    w_wrap_d  = 1'b0;
    w_hit     = 1'b0;
    if (i_load) begin
      w_count_d = i_load_val;
    end else if (w_step && i_enable) begin
      if (i_up_down) begin
        if (r_count == MaxVal) begin
          w_hit = 1'b1;
          if (i_mode == MODE_WRAP) begin
            w_count_d = '0;
            w_wrap_d  = 1'b1;
          end
        end else begin
          w_count_d = r_count + One;
        end
      end else begin
        if (r_count == '0) begin
          w_hit = 1'b1;
          if (i_mode == MODE_WRAP) begin
            w_count_d = MaxVal;
            w_wrap_d  = 1'b1;
          end
        end else begin
          w_count_d = r_count - One;
        end
      end
    end
    // A boundary hit in the same cycle as a clear keeps the flag set.
    w_sticky_d = w_hit | (r_sticky & ~i_clr_flags);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_count  <= ResetVal;
      r_wrap   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_count  <= w_count_d;
      r_wrap   <= w_wrap_d;
      r_sticky <= w_sticky_d;
    end
  end

  assign o_count           = r_count;
  assign o_wrap            = r_wrap;
  assign o_boundary_sticky = r_sticky;

endmodule

// File: tb/tb_event_counter.sv
// Directed and randomised checks of event_counter against a history-based
// reference model of synchronisation, debouncing and counting.
module tb_event_counter;
  import event_counter_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;
  localparam int unsigned D = 4;
  localparam int unsigned MaxV = 65535;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          impulse = 1'b0;
  logic          enable = 1'b1;
  logic          up_down = 1'b1;
  cnt_mode_e     mode = MODE_WRAP;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          clr_flags = 1'b0;
  logic [W-1:0]  count;
  logic          wrap;
  logic          sticky;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: histories since the last reset edge.
  bit imp_hist[$];
  bit sync_hist[$];
  bit rise_hist[$];
  bit m_level;
  int m_count;
  bit m_wrap;
  bit m_sticky;

  event_counter #(
    .WIDTH          (W),
    .RESET_VAL      (32'hFF00),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_impulse        (impulse),
    .i_enable         (enable),
    .i_up_down        (up_down),
    .i_mode           (mode),
    .i_load           (load),
    .i_load_val       (load_val),
    .i_clr_flags      (clr_flags),
    .o_count          (count),
    .o_wrap           (wrap),
    .o_boundary_sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit seen;
    bit all_diff;
    bit rise;
    bit step_now;
    bit hit;
    int n;
    if (!nrst) begin
      imp_hist.delete();
      sync_hist.delete();
      rise_hist.delete();
      m_level  = 0;
      m_count  = 'hFF00;
      m_wrap   = 0;
      m_sticky = 0;
      return;
    end
    // The synchronised value seen now is the input sampled S edges ago.
    seen = (imp_hist.size() >= S) ? imp_hist[imp_hist.size() - S] : 1'b0;
    imp_hist.push_back(impulse);
    sync_hist.push_back(seen);
    n = sync_hist.size();
    all_diff = (n >= D);
    for (int i = 0; i < D && i < n; i++) if (sync_hist[n - 1 - i] == m_level) all_diff = 0;
    rise = 0;
    if (all_diff) begin
      m_level = ~m_level;
      rise = m_level;
    end
    // A rise becomes a registered step, which the count applies one edge later.
    step_now = (rise_hist.size() >= 2) ? rise_hist[rise_hist.size() - 2] : 1'b0;
    rise_hist.push_back(rise);
    m_wrap = 0;
    hit = 0;
    if (load) begin
      m_count = int'(load_val);
    end else if (step_now && enable) begin
      if (up_down) begin
        if (m_count + 1 > MaxV) begin
          hit = 1;
          if (mode == MODE_WRAP) begin m_count = 0; m_wrap = 1; end
        end else m_count = m_count + 1;
      end else begin
        if (m_count - 1 < 0) begin
          hit = 1;
          if (mode == MODE_WRAP) begin m_count = MaxV; m_wrap = 1; end
        end else m_count = m_count - 1;
      end
    end
    if (hit) m_sticky = 1;
    else if (clr_flags) m_sticky = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("count", 32'(count), 32'(m_count));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("sticky", 32'(sticky), 32'(m_sticky));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int hi, input int lo);
    impulse = 1'b1;
    ticks(hi);
    impulse = 1'b0;
    ticks(lo);
  endtask

  initial begin
    int wraps;
    logic [W-1:0] vals [5];
    vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'hFFFE; vals[3] = 16'hFFFF;
    vals[4] = 16'h8000;

    // Reset
    nrst = 1'b0;
    ticks(3);
    nrst = 1'b1;
    check("reset_count", 32'(count), 32'hFF00);
    check("reset_sticky", 32'(sticky), 32'h0);

    // Held press: exactly one step, seven edges after the first sampling edge
    impulse = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("press_latency", 32'(count), (i >= 7) ? 32'hFF01 : 32'hFF00);
    end
    impulse = 1'b0;
    ticks(10);
    check("press_single", 32'(count), 32'hFF01);

    // Glitches shorter than the debounce window
    for (int i = 0; i < 5; i++) press(3, 2);
    ticks(10);
    check("glitch", 32'(count), 32'hFF01);

    // Wrap at the top
    load = 1'b1; load_val = 16'hFFFF; mode = MODE_WRAP; up_down = 1'b1;
    tick();
    load = 1'b0;
    wraps = 0;
    impulse = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) impulse = 1'b0;
      tick();
      if (wrap) wraps++;
    end
    check("wrap_count", 32'(count), 32'h0);
    check("wrap_pulses", 32'(wraps), 32'h1);
    check("wrap_sticky", 32'(sticky), 32'h1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_sticky", 32'(sticky), 32'h0);

    // Saturate at the bottom
    load = 1'b1; load_val = 16'h0000; mode = MODE_SAT; up_down = 1'b0;
    tick();
    load = 1'b0;
    wraps = 0;
    impulse = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) impulse = 1'b0;
      tick();
      if (wrap) wraps++;
    end
    check("sat_count", 32'(count), 32'h0);
    check("sat_wrap", 32'(wraps), 32'h0);
    check("sat_sticky", 32'(sticky), 32'h1);

    // Load coincident with the step edge wins
    up_down = 1'b1;
    impulse = 1'b1;
    ticks(7);
    load = 1'b1; load_val = 16'h1234;
    tick();
    load = 1'b0;
    check("load_prio", 32'(count), 32'h1234);
    ticks(5);
    impulse = 1'b0;
    ticks(10);
    check("load_hold", 32'(count), 32'h1234);

    // Disabled steps are discarded
    enable = 1'b0;
    press(10, 10);
    check("disabled", 32'(count), 32'h1234);
    enable = 1'b1;

    // Reset in the middle of a debounce run
    impulse = 1'b1;
    ticks(4);
    nrst = 1'b0;
    ticks(2);
    nrst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("reset_mid", 32'(count), (i >= 7) ? 32'hFF01 : 32'hFF00);
    end
    impulse = 1'b0;
    ticks(10);

    // Randomised traffic near and away from the boundaries
    for (int seg = 0; seg < 300; seg++) begin
      enable    = ($urandom_range(0, 9) < 8);
      up_down   = 1'($urandom_range(0, 1));
      mode      = cnt_mode_e'($urandom_range(0, 1));
      clr_flags = ($urandom_range(0, 9) == 0);
      load      = ($urandom_range(0, 14) == 0);
      load_val  = vals[$urandom_range(0, 4)];
      impulse   = 1'($urandom_range(0, 1));
      tick();
      load = 1'b0;
      clr_flags = 1'b0;
      ticks($urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/event_counter.md
EVENT_COUNTER -- requirements
Module: event_counter

Interface
REQ-001 Parameter WIDTH, 16, counter width in bits (2..32).
REQ-002 Parameter RESET_VAL, 'hFF00, count value loaded on reset; truncated to WIDTH bits.
REQ-003 Parameter SYNC_STAGES, 2, synchroniser depth on impulse (>=2).
REQ-004 Parameter DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to accept a level change (>=1).
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 nrst  in  1  reset, synchronous, active-low.
REQ-007 impulse  in  1  asynchronous raw pushbutton/event input.
REQ-008 enable  in  1  1 = accepted steps modify count.
REQ-009 up_down  in  1  1 = increment, 0 = decrement.
REQ-010 mode  in  cnt_mode_e  MODE_WRAP or MODE_SAT.
REQ-011 load  in  1  synchronous load strobe.
REQ-012 load_val  in  WIDTH  value for load.
REQ-013 clr_flags  in  1  clears the sticky boundary flag.
REQ-014 count  out  WIDTH  registered count value.
REQ-015 wrap  out  1  one-cycle pulse on wrap-around.
REQ-016 boundary_sticky  out  1  set on any wrap or saturation hit.

Function
REQ-017 impulse SHALL pass through SYNC_STAGES flops before any other use.
REQ-018 The debounced level SHALL toggle on the edge at which the synchronised sample has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts the run.
REQ-019 A step SHALL be a one-cycle registered pulse, asserted the cycle after the debounced level rises 0->1; falling edges produce no step.
REQ-020 Latency from the first clock edge sampling impulse high (held stable) to count update SHALL be SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
REQ-021 Priority: load > step; on load, count <= load_val and a same-cycle step is discarded.
REQ-022 With enable=0, steps SHALL be discarded; debouncing continues.
REQ-023 Up step, count < 2^WIDTH-1: count+1; at 2^WIDTH-1: MODE_WRAP -> 0 with wrap=1, MODE_SAT -> hold.
REQ-024 Down step, count > 0: count-1; at 0: MODE_WRAP -> 2^WIDTH-1 with wrap=1, MODE_SAT -> hold.
REQ-025 boundary_sticky SHALL set on any wrap or saturated-hold step and remain set until clr_flags; set wins over a same-cycle clr_flags.
REQ-026 mode/up_down SHALL be sampled in the cycle the step is applied; changes never alter count by themselves.

Reset
REQ-027 While nrst=0: count=RESET_VAL, wrap=0, boundary_sticky=0, synchroniser flops, debounced level, run counter and step all 0.
REQ-028 impulse held high through reset release SHALL yield exactly one step, REQ-020 latency after release.
REQ-029 Reset mid-debounce SHALL discard the partial run; no step is generated from pre-reset samples.

Structure
REQ-030 Package event_counter_pkg SHALL hold typedef enum cnt_mode_e {MODE_WRAP, MODE_SAT}.
REQ-031 Synchroniser, debounce run counter ($clog2(DEBOUNCE_CYCLES+1) bits) and rising-edge pulse SHALL live in sub-module debouncer; event_counter holds the count datapath and flags.

Verification (bench overrides DEBOUNCE_CYCLES=4, WIDTH=16)
REQ-032 Reset -> count=16'hFF00; impulse high 20 cycles -> count=16'hFF01 exactly 7 cycles after first sampling edge, single step.
REQ-033 Glitches of 3 cycles high, 2 low, repeated 5 times -> count unchanged.
REQ-034 load 16'hFFFF, MODE_WRAP, up press -> count=0, wrap high one cycle, boundary_sticky=1; clr_flags -> 0.
REQ-035 load 0, MODE_SAT, down press -> count stays 0, wrap=0, boundary_sticky=1.
REQ-036 load=1 with load_val 16'h1234 coincident with step -> count=16'h1234; enable=0 press -> no change.
REQ-037 nrst low for 2 cycles during debounce run -> count=RESET_VAL; held impulse -> one step 7 cycles after release.
